// File: rtl/data_mem_server_pkg.sv
// Shared constants and FSM state type for the DMem server.
package data_mem_server_pkg;
  localparam int DMEM_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: synchronous write, combinational read.
module data_mem_array
  import data_mem_server_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DMEM_W-1:0] wdata,
  output logic [DMEM_W-1:0] rdata
);
  logic [DMEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_server.sv
// DMem server: accepts one request, waits LATENCY cycles, then performs the
// array access and holds the response until the next request is accepted.
module data_mem_server
  import data_mem_server_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              request__ENA,
  input  logic [DMEM_W-1:0] request_write_en,
  input  logic [DMEM_W-1:0] request_addr,
  input  logic [DMEM_W-1:0] request_data,
  output logic              request__RDY,
  output logic [DMEM_W-1:0] response,
  output logic              response__RDY
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  // Handshake: a request transfers on any rising edge where request__ENA and
  // request__RDY are both 1; ENA while RDY=0 is ignored. response is valid
  // exactly while response__RDY=1 and never changes while it is 1.

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DMEM_W-1:0] data_q, data_d;
  logic [DMEM_W-1:0] resp_q, resp_d;
  logic              mem_we;
  logic [DMEM_W-1:0] mem_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{request_addr[DMEM_W-1:AW+2], request_addr[1:0]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wr_d    = wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    resp_d  = resp_q;
    mem_we  = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (request__ENA) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          wr_d    = |request_write_en;
          idx_d   = request_addr[AW+1:2];
          data_d  = request_data;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_d = RESP;
          mem_we  = wr_q;
          resp_d  = wr_q ? data_q : mem_rdata;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      resp_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      wr_q   <= wr_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      resp_q <= resp_d;
    end
  end

  // Reset on the completing edge aborts the write as well as the response.
  data_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (CLK),
    .we    (mem_we & ~RST),
    .addr  (idx_q),
    .wdata (data_q),
    .rdata (mem_rdata)
  );

  assign request__RDY  = (state != BUSY);
  assign response__RDY = (state == RESP);
  assign response      = resp_q;
endmodule

// File: tb/tb_data_mem_server.sv
// Bench for data_mem_server: directed table on a LATENCY=2 instance plus
// random traffic on LATENCY=1 and LATENCY=15 instances against a word model.
module tb_data_mem_server;
  logic clk = 1'b0;
  logic rst;
  logic [2:0]        ena;
  logic [2:0][31:0]  wen, addr, wdata, resp;
  logic [2:0]        rrdy, vrdy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_m [3][16];

  always #5 clk = ~clk;

  data_mem_server #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .CLK(clk), .RST(rst), .request__ENA(ena[0]), .request_write_en(wen[0]),
    .request_addr(addr[0]), .request_data(wdata[0]), .request__RDY(rrdy[0]),
    .response(resp[0]), .response__RDY(vrdy[0]));
  data_mem_server #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RST(rst), .request__ENA(ena[1]), .request_write_en(wen[1]),
    .request_addr(addr[1]), .request_data(wdata[1]), .request__RDY(rrdy[1]),
    .response(resp[1]), .response__RDY(vrdy[1]));
  data_mem_server #(.DEPTH(16), .LATENCY(15)) u_dut2 (
    .CLK(clk), .RST(rst), .request__ENA(ena[2]), .request_write_en(wen[2]),
    .request_addr(addr[2]), .request_data(wdata[2]), .request__RDY(rrdy[2]),
    .response(resp[2]), .response__RDY(vrdy[2]));

  function automatic int lat_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One transaction on instance k. With poke=1 a junk write is held on the
  // request pins for the first BUSY edge, which the DUT must ignore.
  task automatic xact(input int k, input logic [31:0] we_v, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp,
                      input bit poke, input string name);
    int   w = 0;
    logic early = 1'b0;
    @(negedge clk);
    while (rrdy[k] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, " req_rdy"}, 32'(rrdy[k]), 32'd1);
    exp_q.push_back(exp);
    ena[k] = 1'b1; wen[k] = we_v; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    if (poke) begin
      wen[k] = 32'd1; wdata[k] = 32'h0BAD_BAD0;
    end else begin
      ena[k] = 1'b0; wen[k] = '0;
    end
    for (int i = 1; i <= lat_of(k); i++) begin
      @(posedge clk); #1;
      ena[k] = 1'b0; wen[k] = '0;
      if (i < lat_of(k) && vrdy[k] !== 1'b0) early = 1'b1;
    end
    chk({name, " latency"}, {30'd0, early, vrdy[k]}, 32'd1);
    chk({name, " data"}, resp[k], exp_q.pop_front());
  endtask

  // Accept a write on instance k, then reset on the very next edge.
  task automatic xact_reset(input int k, input logic [31:0] a, input logic [31:0] d,
                            input string name);
    @(negedge clk);
    ena[k] = 1'b1; wen[k] = 32'd1; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    ena[k] = 1'b0; wen[k] = '0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk({name, " req_rdy"}, 32'(rrdy[k]), 32'd1);
    chk({name, " rsp_rdy"}, 32'(vrdy[k]), 32'd0);
    chk({name, " rsp_zero"}, resp[k], 32'd0);
  endtask

  typedef struct {
    logic [31:0] we_v;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [31:0] a, d, e, w;
    int idx;
    tbl[0] = '{32'd1,     32'h10,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "wr_10"};
    tbl[1] = '{32'd0,     32'h10,  32'h0,         32'hDEAD_BEEF, "rd_10"};
    tbl[2] = '{32'd0,     32'h413, 32'h0,         32'hDEAD_BEEF, "rd_413_wrap"};
    tbl[3] = '{32'd1,     32'h20,  32'h1234_5678, 32'h1234_5678, "wr_20"};
    tbl[4] = '{32'd0,     32'h20,  32'hFFFF_FFFF, 32'h1234_5678, "rd_20_in_resp"};
    tbl[5] = '{32'h100,   32'h30,  32'h1,         32'h1,         "wr_30_hi_en"};
    tbl[6] = '{32'h8000_0000, 32'h40B, 32'hCAFE_F00D, 32'hCAFE_F00D, "wr_40b"};
    tbl[7] = '{32'd0,     32'h8,   32'h0,         32'hCAFE_F00D, "rd_8_alias"};

    rst = 1'b1; ena = '0; wen = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset req_rdy %0d", k), 32'(rrdy[k]), 32'd1);
      chk($sformatf("reset rsp_rdy %0d", k), 32'(vrdy[k]), 32'd0);
      chk($sformatf("reset rsp %0d", k), resp[k], 32'd0);
    end

    for (int i = 0; i < 8; i++)
      xact(0, tbl[i].we_v, tbl[i].a, tbl[i].d, tbl[i].exp, 1'b0, tbl[i].name);

    // Request pulsed while BUSY must neither restart nor write.
    xact(0, 32'd0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, "busy_poke");
    xact(0, 32'd0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "after_poke");

    // Response holds while no new request arrives.
    repeat (3) @(negedge clk);
    chk("hold rsp_rdy", 32'(vrdy[0]), 32'd1);
    chk("hold rsp", resp[0], 32'hDEAD_BEEF);

    xact_reset(0, 32'h30, 32'hAAAA_5555, "rst_busy");
    xact(0, 32'd0, 32'h30, 32'h0, 32'h1, 1'b0, "rd_30_after_rst");

    // Random traffic on the LATENCY=1 and LATENCY=15 instances.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom;
        ref_m[k][i] = d;
        xact(k, 32'd1, 32'(i * 4), d, d, 1'b0, $sformatf("init%0d_%0d", k, i));
      end
      for (int i = 0; i < 20; i++) begin
        a = 32'($urandom_range(0, 255));
        idx = int'((a >> 2) & 32'hF);
        if ($urandom_range(0, 1) == 1) begin
          w = 32'($urandom_range(1, 65535));
          d = $urandom;
          ref_m[k][idx] = d;
          e = d;
        end else begin
          w = 32'd0;
          d = $urandom;
          e = ref_m[k][idx];
        end
        xact(k, w, a, d, e, 1'b0, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    // Reset landing on the completing edge (LATENCY=1) must not write.
    xact_reset(1, 32'h4, 32'h2222_2222, "rst_on_write_edge");
    xact(1, 32'd0, 32'h4, 32'h0, ref_m[1][1], 1'b0, "rd_4_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/data_mem_server.md
DATA_MEM_SERVER -- requirements
Module: data_mem_server

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEPTH, 256: number of 32-bit words in the array; power of two, minimum 2.
- LATENCY, 2: cycles from request accept to response__RDY; legal range 1..15.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: the single clock.
- RST, in, 1: synchronous, active-high reset.
- request__ENA, in, 1: request fire.
- request$write_en, in, 32: a nonzero value means write.
- request$addr, in, 32: byte address.
- request$data, in, 32: write data.
- request__RDY, out, 1: a request may be accepted this cycle.
- response, out, 32: result data.
- response__RDY, out, 1: response is valid.
REQ-003 The block SHALL be a server of the shared DMem interface: the request action method plus the response value method.
REQ-004 Clocking SHALL be a single clock, CLK. Reset SHALL be synchronous and active-high on RST, sampled only on the CLK rising edge.

Function
REQ-005 The block SHALL implement a 3-state FSM:
- IDLE: no request outstanding, no response held.
- BUSY: a request is in flight.
- RESP: a response is held.
REQ-006 request__RDY SHALL be 1 exactly in IDLE and RESP. request__ENA while request__RDY=0 is a caller protocol error; the block SHALL ignore it and leave its state unchanged.
REQ-007 An accepted request (request__ENA && request__RDY) SHALL do all of the following in the same edge:
- latch write_en!=0, the word index and the data;
- load the latency counter with LATENCY-1;
- go to BUSY;
- drop response__RDY on the following cycle.
REQ-008 The word index SHALL be addr[log2(DEPTH)+1:2]. Bits [1:0] and all higher bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-009 In BUSY the counter SHALL decrement by 1 per cycle. The block SHALL move to RESP on the edge where the counter is 0.
REQ-010 With accept at edge N, response__RDY SHALL be 1 in the cycle following edge N+LATENCY.
REQ-011 On the BUSY->RESP edge:
- Read: response SHALL load array[index].
- Write: array[index] SHALL be written with data, and response SHALL load the written data.
REQ-012 The array SHALL be written only on the BUSY->RESP edge. It SHALL never be written at accept time and never in IDLE or RESP.
REQ-013 response and response__RDY SHALL hold stable in RESP until the next request is accepted. response is a value method; reading it has no side effect.
REQ-014 A request accepted in RESP SHALL discard the held response and re-enter BUSY in the same edge. Back-to-back throughput SHALL therefore be one request per LATENCY+1 cycles.
REQ-015 A write followed by a read of the same index SHALL return the new value (read-after-write through the array).
REQ-016 response__RDY SHALL be 0 in IDLE and BUSY. response SHALL keep its last loaded value outside RESP.

Reset
REQ-017 When RST=1 at an edge, the block SHALL go to IDLE and set the counter to 0, response to 0 and response__RDY to 0. request__RDY SHALL be 1 in the first cycle after reset.
REQ-018 Reset asserted while in BUSY SHALL abort the request. A write in flight SHALL NOT modify the array.
REQ-019 Array contents SHALL NOT be cleared by reset.

Structure
REQ-020 A shared package SHALL hold:
- the DMem width constant (32);
- the FSM state enum (IDLE, BUSY, RESP);
- the LATENCY counter width (4).
REQ-021 Storage SHALL be one sub-module, data_mem_array: single-port, synchronous write, combinational read, parameterised by DEPTH.
REQ-022 The FSM and counter SHALL live in data_mem_server. No other hierarchy is permitted.

Verification
REQ-023 Reset, then write addr 0x10 with data 0xDEADBEEF (LATENCY=2) -> response__RDY=1 exactly 2 cycles after accept, response=0xDEADBEEF.
REQ-024 Read addr 0x10 -> response=0xDEADBEEF after 2 cycles. Read addr 0x413 with DEPTH=256 -> same word (wrap plus low-bit ignore).
REQ-025 A request pulsed in BUSY -> ignored: no state change and no array write; the original response still arrives on schedule.
REQ-026 Write 0x12345678 to addr 0x20, then a new read of 0x20 accepted while in RESP, same cycle -> response__RDY drops for 2 cycles, then response=0x12345678.
REQ-027 RST asserted 1 cycle after accepting a write of 0xAAAA5555 to addr 0x30 (prior content 0x1) -> IDLE, request__RDY=1, response__RDY=0; a later read of 0x30 returns 0x1.
REQ-028 Sweep LATENCY=1 and 15 with random read/write traffic against a reference model -> latency is exact and all data matches.
